// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter controller for the 16-bit single-cycle CPU. Owns the PC
//   register, selects the next fetch address from sequential, branch, jump,
//   interrupt-vector or return-from-interrupt sources, and manages stall,
//   halt and a single-level interrupt with a saved return address (EPC).
//
// Ports
//   clk           in   system clock, rising-edge active
//   rst           in   asynchronous active-high reset
//   stall         in   hold PC and all state (a pending irq stays latched)
//   halt          in   enter HALT; only rst leaves it
//   jump          in   absolute jump request
//   jump_target   in   [15:0] jump address, bit 0 forced to 0
//   branch_taken  in   PC-relative branch request
//   branch_offset in   [7:0] signed word offset
//   reti          in   return from interrupt
//   irq           in   interrupt request (level or pulse, latched)
//   pc            out  [15:0] current fetch address
//   pc_plus2      out  [15:0] pc + 2, wrapping
//   pc_valid      out  pc is a valid fetch this cycle
//   epc           out  [15:0] saved return address
//   irq_ack       out  one-cycle pulse during the interrupt-entry bubble
//   int_en        out  interrupts enabled
//   halted        out  high in HALT
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] IRQ_VEC   = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  input  logic        reti,
  input  logic        irq,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        pc_valid,
  output logic [15:0] epc,
  output logic        irq_ack,
  output logic        int_en,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IRQ_ENTRY = 2'd1,
    HALT      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic        int_en_q, int_en_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_ack_q, irq_ack_d;
  logic [15:0] nxt;
  logic [15:0] branch_disp;

  // Sign-extended word offset scaled to bytes.
  assign branch_disp = {{7{branch_offset[7]}}, branch_offset, 1'b0};
  assign pc_plus2    = pc_q + 16'd2;

  // Candidate next PC; reti outranks jump, which outranks branch.
  always_comb begin
    if (reti)              nxt = epc_q;
    else if (jump)         nxt = jump_target & 16'hFFFE;
    else if (branch_taken) nxt = pc_plus2 + branch_disp;
    else                   nxt = pc_plus2;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    int_en_d      = int_en_q;
    irq_ack_d     = 1'b0;
    irq_pending_d = irq_pending_q | irq;

    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (stall) begin
          // Everything holds; only the irq latch keeps sampling.
        end else if (irq_pending_q && int_en_q) begin
          pc_d          = IRQ_VEC;
          epc_d         = nxt;
          int_en_d      = 1'b0;
          // A request still high on the accepting edge re-arms the latch.
          irq_pending_d = irq;
          irq_ack_d     = 1'b1;
          state_d       = IRQ_ENTRY;
        end else begin
          pc_d = nxt;
          if (reti) int_en_d = 1'b1;
        end
      end
      IRQ_ENTRY: begin
        state_d = halt ? HALT : RUN;
      end
      HALT: begin
        irq_pending_d = irq_pending_q;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_VEC;
      epc_q         <= 16'h0000;
      int_en_q      <= 1'b1;
      irq_pending_q <= 1'b0;
      irq_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      int_en_q      <= int_en_d;
      irq_pending_q <= irq_pending_d;
      irq_ack_q     <= irq_ack_d;
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign int_en   = int_en_q;
  assign irq_ack  = irq_ack_q;
  assign pc_valid = (state_q == RUN);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. Vectors carry inputs plus the
//   expected post-edge outputs; expectations are queued when a vector is
//   driven and popped for comparison once the clock edge has taken effect.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic        reti;
  logic        irq;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        pc_valid;
  logic [15:0] epc;
  logic        irq_ack;
  logic        int_en;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        halt;
    logic        jump;
    logic [15:0] jt;
    logic        br;
    logic [7:0]  off;
    logic        reti;
    logic        irq;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_ack;
    logic        e_int_en;
    logic [15:0] e_epc;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .halt         (halt),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .reti         (reti),
    .irq          (irq),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .pc_valid     (pc_valid),
    .epc          (epc),
    .irq_ack      (irq_ack),
    .int_en       (int_en),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input vec_t e);
    check({tag, " pc"},       pc,                e.e_pc);
    check({tag, " pc_plus2"}, pc_plus2,          e.e_pc + 16'd2);
    check({tag, " pc_valid"}, {15'd0, pc_valid}, {15'd0, e.e_valid});
    check({tag, " irq_ack"},  {15'd0, irq_ack},  {15'd0, e.e_ack});
    check({tag, " int_en"},   {15'd0, int_en},   {15'd0, e.e_int_en});
    check({tag, " epc"},      epc,               e.e_epc);
    check({tag, " halted"},   {15'd0, halted},   {15'd0, e.e_halted});
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    stall         = v.stall;
    halt          = v.halt;
    jump          = v.jump;
    jump_target   = v.jt;
    branch_taken  = v.br;
    branch_offset = v.off;
    reti          = v.reti;
    irq           = v.irq;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_state(tag, e);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; halt = 0; jump = 0; jump_target = 16'h0; branch_taken = 0;
    branch_offset = 8'h0; reti = 0; irq = 0;
  endtask

  initial begin
    vec_t rv;
    // Expected reset state: pc 0000, valid, int_en, epc 0000, no ack, not halted.
    rv = vec_t'{0,0,0,16'h0,0,8'h0,0,0, 16'h0000,1,0,1,16'h0000,0};

    //            st h  j  jt        br off    rt irq  pc        v ack ie epc       hl
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0002,1,0,1,16'h0000,0}); //  1 sequential
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0004,1,0,1,16'h0000,0}); //  2
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0006,1,0,1,16'h0000,0}); //  3
    vecs.push_back(vec_t'{0,0,1,16'hFFFE,0,8'h00,0,0, 16'hFFFE,1,0,1,16'h0000,0}); //  4 pc_plus2 wraps to 0000
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0000,1,0,1,16'h0000,0}); //  5 pc wraps
    vecs.push_back(vec_t'{0,0,1,16'h0100,0,8'h00,0,0, 16'h0100,1,0,1,16'h0000,0}); //  6
    vecs.push_back(vec_t'{0,0,0,16'h0000,1,8'hFC,0,0, 16'h00FA,1,0,1,16'h0000,0}); //  7 backward branch
    vecs.push_back(vec_t'{0,0,1,16'h1235,0,8'h00,0,0, 16'h1234,1,0,1,16'h0000,0}); //  8 bit 0 forced low
    vecs.push_back(vec_t'{0,0,1,16'h0300,1,8'h10,0,0, 16'h0300,1,0,1,16'h0000,0}); //  9 jump beats branch
    vecs.push_back(vec_t'{0,0,1,16'h0200,0,8'h00,0,1, 16'h0200,1,0,1,16'h0000,0}); // 10 irq latched
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0010,0,1,0,16'h0202,0}); // 11 accept
    vecs.push_back(vec_t'{1,0,1,16'h4444,1,8'h05,1,0, 16'h0010,1,0,0,16'h0202,0}); // 12 bubble ignores inputs
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0012,1,0,0,16'h0202,0}); // 13
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,1,0, 16'h0202,1,0,1,16'h0202,0}); // 14 reti
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0204,1,0,1,16'h0202,0}); // 15
    vecs.push_back(vec_t'{1,0,0,16'h0000,0,8'h00,0,1, 16'h0204,1,0,1,16'h0202,0}); // 16 stall, irq pulse
    vecs.push_back(vec_t'{1,0,1,16'h7000,0,8'h00,0,0, 16'h0204,1,0,1,16'h0202,0}); // 17 stall holds
    vecs.push_back(vec_t'{1,0,0,16'h0000,0,8'h00,0,0, 16'h0204,1,0,1,16'h0202,0}); // 18
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0010,0,1,0,16'h0206,0}); // 19 accept after stall
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0010,1,0,0,16'h0206,0}); // 20
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,1, 16'h0012,1,0,0,16'h0206,0}); // 21 masked irq
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0014,1,0,0,16'h0206,0}); // 22 still no ack
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,1,0, 16'h0206,1,0,1,16'h0206,0}); // 23 reti re-enables
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0010,0,1,0,16'h0208,0}); // 24 pending accepted
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0010,1,0,0,16'h0208,0}); // 25
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,1,0, 16'h0208,1,0,1,16'h0208,0}); // 26 reti
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,1, 16'h020A,1,0,1,16'h0208,0}); // 27 irq latched
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,1,0, 16'h0010,0,1,0,16'h0208,0}); // 28 reti + accept
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,1, 16'h0010,1,0,0,16'h0208,0}); // 29 irq pending, masked
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0012,1,0,0,16'h0208,0}); // 30
    vecs.push_back(vec_t'{0,1,0,16'h0000,0,8'h00,0,0, 16'h0012,0,0,0,16'h0208,1}); // 31 halt
    vecs.push_back(vec_t'{0,0,1,16'h5000,0,8'h00,1,1, 16'h0012,0,0,0,16'h0208,1}); // 32 inputs ignored
    vecs.push_back(vec_t'{0,0,0,16'h0000,0,8'h00,0,0, 16'h0012,0,0,0,16'h0208,1}); // 33

    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 check_state("async_reset", rv);
    @(posedge clk);
    #1 check_state("reset_held", rv);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i + 1), vecs[i]);
    end

    // Asynchronous reset in the middle of a HALT cycle, with an irq pending.
    #3 rst = 1'b1;
    #1 check_state("rst_mid_halt", rv);
    @(posedge clk);
    #1 rst = 1'b0;
    // Pending irq must have been dropped by reset: no acceptance here.
    apply("post_rst", vec_t'{0,0,0,16'h0,0,8'h0,0,0, 16'h0002,1,0,1,16'h0000,0});

    // halt during the IRQ_ENTRY bubble goes straight to HALT.
    apply("h_irq",    vec_t'{0,0,0,16'h0,0,8'h0,0,1, 16'h0004,1,0,1,16'h0000,0});
    apply("h_accept", vec_t'{0,0,0,16'h0,0,8'h0,0,0, 16'h0010,0,1,0,16'h0006,0});
    apply("h_halt",   vec_t'{0,1,0,16'h0,0,8'h0,0,0, 16'h0010,0,0,0,16'h0006,1});

    // Reset while in IRQ_ENTRY.
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    apply("h_irq2",   vec_t'{0,0,0,16'h0,0,8'h0,0,1, 16'h0002,1,0,1,16'h0000,0});
    apply("h_acc2",   vec_t'{0,0,0,16'h0,0,8'h0,0,0, 16'h0010,0,1,0,16'h0004,0});
    #3 rst = 1'b1;
    #1 check_state("rst_mid_entry", rv);
    rst = 1'b0;

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
